// File: rtl/rand_pkg.sv
// Shared constants and types for the multi-channel pseudo-random source.
//   MODE_LCG / MODE_XORSHIFT : generator algorithm selectors
//   LCG_A, LCG_B, DEF_SEED    : default LCG constants and reset seed
//   XS_SH1..XS_SH3            : default xorshift shift amounts
//   state_t                   : request control FSM states
//   chan_seed()               : per-channel reset seed (base ^ channel)
package rand_pkg;

    localparam int MODE_LCG      = 0;
    localparam int MODE_XORSHIFT = 1;

    localparam logic [63:0] LCG_A    = 64'd60061;
    localparam logic [63:0] LCG_B    = 64'd55511;
    localparam logic [63:0] DEF_SEED = 64'hdeadbeef;

    localparam int XS_SH1 = 13;
    localparam int XS_SH2 = 17;
    localparam int XS_SH3 = 5;

    // ST_S1 is the single cycle the stage-1 register is busy; the commit
    // happens on the edge that leaves it.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_S1   = 1'b1
    } state_t;

    function automatic logic [63:0] chan_seed(input logic [63:0] base,
                                              input int unsigned c);
        return base ^ 64'(c);
    endfunction

endpackage

// File: rtl/rand_core.sv
// One channel of the pseudo-random source: a two-stage datapath.
//   clk, reset : clock, synchronous active-high reset
//   step       : capture the stage-1 result from the current value
//   finish     : commit the stage-2 result into data
//   seed_load  : load seed into data (overrides finish)
//   seed       : seed value
//   kill       : suppress the commit for this channel
//   data       : current channel value (registered)
module rand_core
    import rand_pkg::*;
#(
    parameter int          WIDTH_D      = 32,
    parameter int          MODE         = MODE_LCG,
    parameter logic [63:0] A            = LCG_A,
    parameter logic [63:0] B            = LCG_B,
    parameter logic [63:0] DEFAULT_SEED = DEF_SEED,
    parameter logic [63:0] RESET_SEED   = DEF_SEED,
    parameter int          SH1          = XS_SH1,
    parameter int          SH2          = XS_SH2,
    parameter int          SH3          = XS_SH3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic               finish,
    input  logic               seed_load,
    input  logic [WIDTH_D-1:0] seed,
    input  logic               kill,
    output logic [WIDTH_D-1:0] data
);

    localparam logic [WIDTH_D-1:0] A_W   = A[WIDTH_D-1:0];
    localparam logic [WIDTH_D-1:0] B_W   = B[WIDTH_D-1:0];
    localparam logic [WIDTH_D-1:0] DEF_W = DEFAULT_SEED[WIDTH_D-1:0];
    localparam logic [WIDTH_D-1:0] RST_W = RESET_SEED[WIDTH_D-1:0];

    logic [WIDTH_D-1:0] stage1;
    logic [WIDTH_D-1:0] s1_next;
    logic [WIDTH_D-1:0] fin_val;
    logic [WIDTH_D-1:0] seed_val;
    logic [WIDTH_D-1:0] xs1;

    always_comb begin
        s1_next  = '0;
        fin_val  = '0;
        seed_val = seed;
        xs1      = data ^ (data << SH1);
        if (MODE == MODE_XORSHIFT) begin
            s1_next = xs1 ^ (xs1 >> SH2);
            fin_val = stage1 ^ (stage1 << SH3);
            // zero is a fixed point of xorshift
            if (seed == '0) begin
                seed_val = DEF_W;
            end
        end else begin
            s1_next = data * A_W;
            fin_val = stage1 + B_W;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data   <= RST_W;
            stage1 <= '0;
        end else begin
            if (step) begin
                stage1 <= s1_next;
            end
            if (seed_load) begin
                data <= seed_val;
            end else if (finish && !kill) begin
                data <= fin_val;
            end
        end
    end

endmodule

// File: rtl/rand_mc.sv
// Multi-channel pseudo-random source. CHANNELS generators advance together
// on one accepted `next`; two-cycle latency, one value per two cycles.
//   clk, reset : clock, synchronous active-high reset
//   next       : request a new value on every channel (accepted when valid=1)
//   seed       : seed value
//   seed_ch    : channel to seed (out-of-range ignored)
//   seed_we    : seed write strobe
//   valid      : 1 = data stable and a request can be accepted
//   data       : channel c at [c*WIDTH_D +: WIDTH_D]
module rand_mc
    import rand_pkg::*;
#(
    parameter int          WIDTH_D      = 32,
    parameter int          CHANNELS     = 4,
    parameter int          MODE         = MODE_LCG,
    parameter logic [63:0] A            = LCG_A,
    parameter logic [63:0] B            = LCG_B,
    parameter logic [63:0] DEFAULT_SEED = DEF_SEED,
    parameter int          SH1          = XS_SH1,
    parameter int          SH2          = XS_SH2,
    parameter int          SH3          = XS_SH3,
    parameter int          CH_BITS      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        next,
    input  logic [WIDTH_D-1:0]          seed,
    input  logic [CH_BITS-1:0]          seed_ch,
    input  logic                        seed_we,
    output logic                        valid,
    output logic [CHANNELS*WIDTH_D-1:0] data
);

    state_t              state;
    logic [CHANNELS-1:0] kill;
    logic [CHANNELS-1:0] seed_hit;
    logic                step;
    logic                finish;

    always_comb begin
        step   = (state == ST_IDLE) && next;
        finish = (state == ST_S1);
    end

    // A seed landing in the accept cycle or the busy cycle must survive the
    // commit; seeds in the busy cycle already win in the core, the kill bit
    // covers the accept-cycle case where the seed was written one edge early.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            valid <= 1'b1;
            kill  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (next) begin
                        state <= ST_S1;
                        valid <= 1'b0;
                        kill  <= seed_hit;
                    end
                end
                ST_S1: begin
                    state <= ST_IDLE;
                    valid <= 1'b1;
                    kill  <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    valid <= 1'b1;
                    kill  <= '0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign seed_hit[c] = seed_we && (seed_ch == CH_BITS'(c));

        rand_core #(
            .WIDTH_D      (WIDTH_D),
            .MODE         (MODE),
            .A            (A),
            .B            (B),
            .DEFAULT_SEED (DEFAULT_SEED),
            .RESET_SEED   (chan_seed(DEFAULT_SEED, c)),
            .SH1          (SH1),
            .SH2          (SH2),
            .SH3          (SH3)
        ) u_core (
            .clk       (clk),
            .reset     (reset),
            .step      (step),
            .finish    (finish),
            .seed_load (seed_hit[c]),
            .seed      (seed),
            .kill      (kill[c]),
            .data      (data[c*WIDTH_D +: WIDTH_D])
        );
    end

endmodule

// File: tb/tb_rand_mc.sv
module tb_rand_mc;

    localparam int W  = 32;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          next = 1'b0;
    logic [W-1:0]  seed = '0;
    logic [1:0]    seed_ch = '0;
    logic          seed_we = 1'b0;
    logic          valid0, valid1;
    logic [NC*W-1:0] data0, data1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    rand_mc #(.WIDTH_D(W), .CHANNELS(NC), .MODE(0)) dut_lcg (
        .clk(clk), .reset(reset), .next(next), .seed(seed), .seed_ch(seed_ch),
        .seed_we(seed_we), .valid(valid0), .data(data0));

    rand_mc #(.WIDTH_D(W), .CHANNELS(NC), .MODE(1)) dut_xs (
        .clk(clk), .reset(reset), .next(next), .seed(seed), .seed_ch(seed_ch),
        .seed_we(seed_we), .valid(valid1), .data(data1));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference generators, computed on 64-bit and masked
    function automatic logic [31:0] ref_lcg(input logic [31:0] x);
        logic [63:0] p;
        p = {32'd0, x} * 64'd60061 + 64'd55511;
        return p[31:0];
    endfunction

    function automatic logic [31:0] ref_s1(input int m, input logic [31:0] x);
        logic [63:0] p;
        logic [31:0] t;
        if (m == 0) begin
            p = {32'd0, x} * 64'd60061;
            return p[31:0];
        end
        t = x ^ (x << 13);
        return t ^ (t >> 17);
    endfunction

    function automatic logic [31:0] ref_fin(input int m, input logic [31:0] x);
        if (m == 0) return x + 32'd55511;
        return x ^ (x << 5);
    endfunction

    function automatic logic [31:0] seed_for(input int m, input logic [31:0] s);
        if (m == 1 && s == 32'd0) return 32'hdeadbeef;
        return s;
    endfunction

    function automatic logic [31:0] ch(input logic [NC*W-1:0] v, input int c);
        return v[c*W +: W];
    endfunction

    // cycle model of both instances
    logic [31:0]    md [2][NC];
    logic [31:0]    ms [2][NC];
    logic [NC-1:0]  mk [2];
    logic           mv [2];
    logic           mp [2];
    logic           was_rst = 1'b1;
    logic [127:0]   sq0[$];
    logic [127:0]   sq1[$];

    initial begin
        forever begin
            @(posedge clk);
            was_rst = reset;
            for (int m = 0; m < 2; m++) begin
                if (reset) begin
                    for (int c = 0; c < NC; c++) md[m][c] = 32'hdeadbeef ^ 32'(c);
                    mv[m] = 1'b1; mp[m] = 1'b0; mk[m] = '0;
                end else if (mp[m]) begin
                    logic [127:0] v;
                    for (int c = 0; c < NC; c++) begin
                        if (seed_we && seed_ch == 2'(c)) md[m][c] = seed_for(m, seed);
                        else if (!mk[m][c]) md[m][c] = ref_fin(m, ms[m][c]);
                        v[c*W +: W] = md[m][c];
                    end
                    if (m == 0) sq0.push_back(v); else sq1.push_back(v);
                    mk[m] = '0; mp[m] = 1'b0; mv[m] = 1'b1;
                end else begin
                    logic acc;
                    acc = mv[m] && next;
                    for (int c = 0; c < NC; c++) begin
                        logic hit;
                        hit = seed_we && seed_ch == 2'(c);
                        if (acc) begin
                            ms[m][c] = ref_s1(m, md[m][c]);
                            mk[m][c] = hit;
                        end
                        if (hit) md[m][c] = seed_for(m, seed);
                    end
                    if (acc) begin mp[m] = 1'b1; mv[m] = 1'b0; end
                end
            end
        end
    end

    // monitor: valid every cycle, data popped on each DUT commit
    logic mon_en = 1'b0;
    logic pv0 = 1'b1, pv1 = 1'b1;
    int unsigned rises0 = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("valid_lcg", 128'(valid0), 128'(mv[0]));
                check("valid_xs", 128'(valid1), 128'(mv[1]));
                if (valid0 && !pv0 && !was_rst) begin
                    rises0++;
                    check("sb_avail_lcg", 128'(sq0.size() != 0), 128'd1);
                    if (sq0.size() != 0) check("sb_data_lcg", 128'(data0), sq0.pop_front());
                end
                if (valid1 && !pv1 && !was_rst) begin
                    check("sb_avail_xs", 128'(sq1.size() != 0), 128'd1);
                    if (sq1.size() != 0) check("sb_data_xs", 128'(data1), sq1.pop_front());
                end
            end
            pv0 = valid0;
            pv1 = valid1;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_next();
        next = 1'b1; step(); next = 1'b0;
    endtask

    task automatic write_seed(input logic [1:0] c, input logic [31:0] s);
        seed_we = 1'b1; seed_ch = c; seed = s; step(); seed_we = 1'b0;
    endtask

    logic [31:0] exp_ch1;
    int unsigned r0;

    initial begin
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        mon_en = 1'b1;

        for (int c = 0; c < NC; c++) begin
            check("rst_lcg", 128'(ch(data0, c)), 128'(32'hdeadbeef ^ 32'(c)));
            check("rst_xs", 128'(ch(data1, c)), 128'(32'hdeadbeef ^ 32'(c)));
        end
        check("rst_valid", 128'(valid0), 128'd1);

        // first LCG update
        exp_ch1 = ref_lcg(32'hdeadbeee);
        pulse_next();
        check("busy_valid", 128'(valid0), 128'd0);
        step();
        check("lcg_ch0", 128'(ch(data0, 0)), 128'h6115676a);
        check("lcg_ch1", 128'(ch(data0, 1)), 128'(exp_ch1));

        // seed ch0 = 1
        write_seed(2'd0, 32'd1);
        check("seed_ch1_kept", 128'(ch(data0, 1)), 128'(exp_ch1));
        pulse_next(); step();
        check("lcg_seed1", 128'(ch(data0, 0)), 128'h0001c374);

        // xorshift seed 1 and zero replacement
        write_seed(2'd2, 32'd1);
        pulse_next(); step();
        check("xs_seed1", 128'(ch(data1, 2)), 128'h00042021);
        write_seed(2'd2, 32'd0);
        check("xs_seed0", 128'(ch(data1, 2)), 128'hdeadbeef);
        check("lcg_seed0", 128'(ch(data0, 2)), 128'h0);

        // next held for 10 cycles -> 5 commits
        r0 = rises0;
        next = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        next = 1'b0;
        check("hold_updates", 128'(rises0 - r0), 128'd5);

        // seed in the accept cycle (ch3) and the following cycle (ch1)
        next = 1'b1; seed_we = 1'b1; seed_ch = 2'd3; seed = 32'hcafef00d;
        step();
        next = 1'b0; seed_ch = 2'd1; seed = 32'h12345678;
        step();
        seed_we = 1'b0;
        check("kill_ch1", 128'(ch(data0, 1)), 128'h12345678);
        check("kill_ch3", 128'(ch(data0, 3)), 128'hcafef00d);

        // reset during S1
        pulse_next();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < NC; c++)
            check("midrst_data", 128'(ch(data0, c)), 128'(32'hdeadbeef ^ 32'(c)));
        check("midrst_valid", 128'(valid0), 128'd1);
        step(); step();
        check("midrst_stale", 128'(ch(data0, 0)), 128'hdeadbeef);

        // random traffic
        for (int i = 0; i < 200; i++) begin
            next    = ($urandom_range(0, 2) != 0);
            seed_we = ($urandom_range(0, 3) == 0);
            seed_ch = 2'($urandom_range(0, 3));
            seed    = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            step();
        end
        next = 1'b0; seed_we = 1'b0;
        step(); step(); step();

        check("sb_drain_lcg", 128'(sq0.size()), 128'd0);
        check("sb_drain_xs", 128'(sq1.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
